// File: rtl/cmd_arbiter.sv
// Two-requester command arbiter with round-robin fairness and a single outstanding command.
// Optional ack deadline enabled by defining CMD_TIMEOUT_EN.
module cmd_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADDR_W         = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [2:0]        req0_cmd,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req1_valid,
  input  logic [2:0]        req1_cmd,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              grant0,
  output logic              grant1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic              cmd_valid,
  output logic [2:0]        command,
  output logic [ADDR_W-1:0] address,
  input  logic              app_ack,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("cmd_arbiter: TIMEOUT_CYCLES must be in 2..65535");
  end

  state_t              state_reg, state_next;
  logic                cmd_valid_reg, cmd_valid_next;
  logic [2:0]          command_reg, command_next;
  logic [ADDR_W-1:0]   address_reg, address_next;
  logic                last_owner_reg, last_owner_next;
  logic                grant0_reg, grant0_next;
  logic                grant1_reg, grant1_next;
  logic                done0_reg, done0_next;
  logic                done1_reg, done1_next;
  logic                pick;

`ifdef CMD_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]         count_reg, count_next;
  logic                err0_reg, err0_next;
  logic                err1_reg, err1_next;
`endif

  // last_owner_reg is also the owner of the command in flight, since it only changes on grant
  always_comb begin
    state_next      = state_reg;
    cmd_valid_next  = cmd_valid_reg;
    command_next    = command_reg;
    address_next    = address_reg;
    last_owner_next = last_owner_reg;
    grant0_next     = 1'b0;
    grant1_next     = 1'b0;
    done0_next      = 1'b0;
    done1_next      = 1'b0;
    pick            = (req0_valid && req1_valid) ? ~last_owner_reg : req1_valid;
`ifdef CMD_TIMEOUT_EN
    count_next      = count_reg;
    err0_next       = 1'b0;
    err1_next       = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          command_next    = pick ? req1_cmd : req0_cmd;
          address_next    = pick ? req1_addr : req0_addr;
          grant0_next     = ~pick;
          grant1_next     = pick;
          last_owner_next = pick;
          cmd_valid_next  = 1'b1;
          state_next      = ISSUE;
`ifdef CMD_TIMEOUT_EN
          count_next      = '0;
`endif
        end
      end
      ISSUE: begin
        if (app_ack) begin
          done0_next     = ~last_owner_reg;
          done1_next     = last_owner_reg;
          cmd_valid_next = 1'b0;
          state_next     = RELEASE;
        end
`ifdef CMD_TIMEOUT_EN
        else if (count_reg == TIMEOUT_LAST) begin
          err0_next      = ~last_owner_reg;
          err1_next      = last_owner_reg;
          cmd_valid_next = 1'b0;
          state_next     = RELEASE;
        end else begin
          count_next = count_reg + 16'd1;
        end
`endif
      end
      RELEASE: begin
        state_next = IDLE;
      end
      default: begin
        state_next     = IDLE;
        cmd_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      cmd_valid_reg  <= 1'b0;
      command_reg    <= 3'd0;
      address_reg    <= '0;
      last_owner_reg <= 1'b1;
      grant0_reg     <= 1'b0;
      grant1_reg     <= 1'b0;
      done0_reg      <= 1'b0;
      done1_reg      <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      count_reg      <= '0;
      err0_reg       <= 1'b0;
      err1_reg       <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      cmd_valid_reg  <= cmd_valid_next;
      command_reg    <= command_next;
      address_reg    <= address_next;
      last_owner_reg <= last_owner_next;
      grant0_reg     <= grant0_next;
      grant1_reg     <= grant1_next;
      done0_reg      <= done0_next;
      done1_reg      <= done1_next;
`ifdef CMD_TIMEOUT_EN
      count_reg      <= count_next;
      err0_reg       <= err0_next;
      err1_reg       <= err1_next;
`endif
    end
  end

  assign grant0    = grant0_reg;
  assign grant1    = grant1_reg;
  assign done0     = done0_reg;
  assign done1     = done1_reg;
  assign cmd_valid = cmd_valid_reg;
  assign command   = command_reg;
  assign address   = address_reg;
  assign busy      = (state_reg != IDLE);

`ifdef CMD_TIMEOUT_EN
  assign err0 = err0_reg;
  assign err1 = err1_reg;
`else
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_arbiter.sv
// Directed bench for cmd_arbiter; inputs driven 1 time unit after each rising edge,
// outputs checked at that same point (after the registered update).
module tb_cmd_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [2:0] req0_cmd, req1_cmd;
  logic [7:0] req0_addr, req1_addr;
  logic       grant0, grant1, done0, done1, err0, err1;
  logic       cmd_valid;
  logic [2:0] command;
  logic [7:0] address;
  logic       app_ack;
  logic       busy;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  cmd_arbiter #(.TIMEOUT_CYCLES(8), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_addr(req0_addr),
    .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_addr(req1_addr),
    .grant0(grant0), .grant1(grant1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .cmd_valid(cmd_valid), .command(command),
    .address(address), .app_ack(app_ack), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req0_valid = 0; req1_valid = 0; app_ack = 0;
    req0_cmd = 0; req1_cmd = 0; req0_addr = 0; req1_addr = 0;
    step(); step();
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (command !== 3'd0 || address !== 8'h00) begin bad++; $display("FAIL reset_cmd_addr: got %0d/%h want 0/00", command, address); end
    total++; if ({grant0, grant1, done0, done1, err0, err1} !== 6'b0) begin bad++; $display("FAIL reset_pulses: got %b want 000000", {grant0, grant1, done0, done1, err0, err1}); end
    reset = 1'b0;
    step();
    $display("txn reset released");
  endtask

  task automatic test_single();
    req0_valid = 1; req0_cmd = 3'd2; req0_addr = 8'h04;
    step();
    total++; if (grant0 !== 1'b1 || grant1 !== 1'b0) begin bad++; $display("FAIL single_grant: got g0=%b g1=%b want 1 0", grant0, grant1); end
    total++; if (cmd_valid !== 1'b1 || command !== 3'd2 || address !== 8'h04) begin bad++; $display("FAIL single_issue: got v=%b cmd=%0d addr=%h want 1 2 04", cmd_valid, command, address); end
    req0_valid = 0;
    step();
    total++; if (grant0 !== 1'b0 || cmd_valid !== 1'b1 || done0 !== 1'b0) begin bad++; $display("FAIL single_hold: got g0=%b v=%b d0=%b want 0 1 0", grant0, cmd_valid, done0); end
    app_ack = 1;
    step();
    app_ack = 0;
    total++; if (done0 !== 1'b1 || done1 !== 1'b0 || cmd_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL single_done: got d0=%b d1=%b v=%b busy=%b want 1 0 0 1", done0, done1, cmd_valid, busy); end
    step();
    total++; if (busy !== 1'b0 || cmd_valid !== 1'b0 || done0 !== 1'b0 || command !== 3'd2 || address !== 8'h04) begin bad++; $display("FAIL single_gap: got busy=%b v=%b d0=%b cmd=%0d addr=%h want 0 0 0 2 04", busy, cmd_valid, done0, command, address); end
    $display("txn single req0 cmd=2 addr=04 done");
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_owner;
    reset = 1; step(); reset = 0;
    exp_owner = 3'b010;
    req0_cmd = 3'd1; req0_addr = 8'hA0; req1_cmd = 3'd5; req1_addr = 8'hB1;
    for (int r = 0; r < 3; r++) begin
      req0_valid = 1; req1_valid = 1;
      step();
      req0_valid = 0; req1_valid = 0;
      total++; if (grant1 !== exp_owner[r] || grant0 !== ~exp_owner[r]) begin bad++; $display("FAIL rr_grant%0d: got g0=%b g1=%b want g1=%b", r, grant0, grant1, exp_owner[r]); end
      total++; if (command !== (exp_owner[r] ? 3'd5 : 3'd1)) begin bad++; $display("FAIL rr_cmd%0d: got %0d want %0d", r, command, exp_owner[r] ? 5 : 1); end
      app_ack = 1; step(); app_ack = 0;
      total++; if (done1 !== exp_owner[r] || done0 !== ~exp_owner[r]) begin bad++; $display("FAIL rr_done%0d: got d0=%b d1=%b want d1=%b", r, done0, done1, exp_owner[r]); end
      step();
      $display("txn round robin %0d granted requester %0d", r, exp_owner[r]);
    end
  endtask

  task automatic test_busy_request();
    req0_valid = 1; req0_cmd = 3'd3; req0_addr = 8'h10;
    step();
    req0_valid = 0;
    total++; if (grant0 !== 1'b1) begin bad++; $display("FAIL busy_grant0: got %b want 1", grant0); end
    req1_valid = 1; req1_cmd = 3'd6; req1_addr = 8'h20;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (grant1 !== 1'b0 || command !== 3'd3 || address !== 8'h10) begin bad++; $display("FAIL busy_hold%0d: got g1=%b cmd=%0d addr=%h want 0 3 10", i, grant1, command, address); end
    end
    app_ack = 1; step(); app_ack = 0;
    total++; if (done0 !== 1'b1 || grant1 !== 1'b0 || command !== 3'd3) begin bad++; $display("FAIL busy_done0: got d0=%b g1=%b cmd=%0d want 1 0 3", done0, grant1, command); end
    step();
    total++; if (grant1 !== 1'b0) begin bad++; $display("FAIL busy_early_grant1: got %b want 0", grant1); end
    step();
    req1_valid = 0;
    total++; if (grant1 !== 1'b1 || command !== 3'd6 || address !== 8'h20) begin bad++; $display("FAIL busy_grant1: got g1=%b cmd=%0d addr=%h want 1 6 20", grant1, command, address); end
    app_ack = 1; step(); app_ack = 0;
    total++; if (done1 !== 1'b1 || done0 !== 1'b0) begin bad++; $display("FAIL busy_done1: got d1=%b d0=%b want 1 0", done1, done0); end
    step();
    $display("txn busy request served req0 then req1");
  endtask

  task automatic test_timeout();
    req0_valid = 1; req0_cmd = 3'd4; req0_addr = 8'h55;
    step();
    req0_valid = 0;
`ifdef CMD_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      total++; if (cmd_valid !== 1'b1 || err0 !== 1'b0) begin bad++; $display("FAIL timeout_wait%0d: got v=%b e0=%b want 1 0", i, cmd_valid, err0); end
      step();
    end
    total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL timeout_last_issue: got v=%b want 1", cmd_valid); end
    step();
    total++; if (err0 !== 1'b1 || err1 !== 1'b0 || done0 !== 1'b0 || cmd_valid !== 1'b0) begin bad++; $display("FAIL timeout_err: got e0=%b e1=%b d0=%b v=%b want 1 0 0 0", err0, err1, done0, cmd_valid); end
    step();
    total++; if (err0 !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL timeout_after: got e0=%b busy=%b want 0 0", err0, busy); end
    $display("txn timeout err0 after 8 issue cycles");
`else
    for (int i = 0; i < 100; i++) step();
    total++; if (cmd_valid !== 1'b1 || busy !== 1'b1 || err0 !== 1'b0) begin bad++; $display("FAIL no_timeout_hold: got v=%b busy=%b e0=%b want 1 1 0", cmd_valid, busy, err0); end
    app_ack = 1; step(); app_ack = 0;
    total++; if (done0 !== 1'b1 || cmd_valid !== 1'b0) begin bad++; $display("FAIL no_timeout_done: got d0=%b v=%b want 1 0", done0, cmd_valid); end
    step();
    $display("txn no timeout, held 100 cycles then acked");
`endif
  endtask

  task automatic test_ack_on_timeout();
    req0_valid = 1; req0_cmd = 3'd7; req0_addr = 8'h66;
    step();
    req0_valid = 0;
    for (int i = 0; i < 7; i++) step();
    app_ack = 1; step(); app_ack = 0;
    total++; if (done0 !== 1'b1 || err0 !== 1'b0 || err1 !== 1'b0) begin bad++; $display("FAIL ack_on_timeout: got d0=%b e0=%b e1=%b want 1 0 0", done0, err0, err1); end
    step();
    $display("txn ack on deadline cycle gives done");
  endtask

  task automatic test_reset_in_issue();
    req0_valid = 1; req0_cmd = 3'd1; req0_addr = 8'h77;
    step();
    req0_valid = 0;
    total++; if (grant0 !== 1'b1) begin bad++; $display("FAIL rst_issue_grant: got %b want 1", grant0); end
    reset = 1; app_ack = 1;
    step();
    reset = 0; app_ack = 0;
    total++; if (busy !== 1'b0 || cmd_valid !== 1'b0 || {done0, done1, err0, err1} !== 4'b0) begin bad++; $display("FAIL rst_issue_abort: got busy=%b v=%b dd/ee=%b want 0 0 0000", busy, cmd_valid, {done0, done1, err0, err1}); end
    req0_valid = 1; req1_valid = 1; req0_cmd = 3'd2; req1_cmd = 3'd3;
    step();
    req0_valid = 0; req1_valid = 0;
    total++; if (grant0 !== 1'b1 || grant1 !== 1'b0 || command !== 3'd2) begin bad++; $display("FAIL rst_issue_regrant: got g0=%b g1=%b cmd=%0d want 1 0 2", grant0, grant1, command); end
    app_ack = 1; step(); app_ack = 0;
    step();
    $display("txn reset during issue aborted, req0 regranted");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_busy_request();
    test_timeout();
    test_ack_on_timeout();
    test_reset_in_issue();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
